// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg: shared definitions for the 7-segment capture path.
//   - Segment patterns for digits 0-9 and blank, laid out as bit7..bit1 = a..g and bit0 = dp.
//     The display driver's encoder uses the same constants.
//   - Nibble codes for a blank digit and an undecodable digit.
//   - FSM state encoding for the digit acceptance machine.
package seg_capture_pkg;

    localparam logic [7:0] Seg0     = 8'hFC;
    localparam logic [7:0] Seg1     = 8'h60;
    localparam logic [7:0] Seg2     = 8'hDA;
    localparam logic [7:0] Seg3     = 8'hF2;
    localparam logic [7:0] Seg4     = 8'h66;
    localparam logic [7:0] Seg5     = 8'hB6;
    localparam logic [7:0] Seg6     = 8'hBE;
    localparam logic [7:0] Seg7     = 8'hE0;
    localparam logic [7:0] Seg8     = 8'hFE;
    localparam logic [7:0] Seg9     = 8'hF6;
    localparam logic [7:0] SegBlank = 8'h00;

    localparam logic [3:0] NibBlank = 4'hA;
    localparam logic [3:0] NibErr   = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold
    } state_e;

endpackage

// File: rtl/seg_capture_segdecode.sv
// seg_capture_segdecode: combinational 7-segment pattern to BCD decoder.
//   seg_i    in  8  segment lines a..g in bits 7..1, dp in bit 0
//   nibble_o out 4  decoded digit, NibBlank for all-off, NibErr otherwise
//   dp_o     out 1  decimal point, passed through
//   err_o    out 1  pattern is neither a digit nor blank
module seg_capture_segdecode
    import seg_capture_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       dp_o,
    output logic       err_o
);

    always_comb begin
        nibble_o = NibErr;
        err_o    = 1'b0;
        dp_o     = seg_i[0];
        // Match with dp forced low so the decimal point never affects the digit.
        case ({seg_i[7:1], 1'b0})
            Seg0:     nibble_o = 4'd0;
            Seg1:     nibble_o = 4'd1;
            Seg2:     nibble_o = 4'd2;
            Seg3:     nibble_o = 4'd3;
            Seg4:     nibble_o = 4'd4;
            Seg5:     nibble_o = 4'd5;
            Seg6:     nibble_o = 4'd6;
            Seg7:     nibble_o = 4'd7;
            Seg8:     nibble_o = 4'd8;
            Seg9:     nibble_o = 4'd9;
            SegBlank: nibble_o = NibBlank;
            default:  err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: reads back a multiplexed 7-segment bus into BCD digits.
//   clk         in  1         clock
//   rst_n       in  1         asynchronous active-low reset
//   segment     in  8         a..g in bits 7..1, dp in bit 0
//   digit_sel   in  DIGITS    one-hot digit select
//   bcd         out 4*DIGITS  last complete frame, nibble i = digit i
//   dp          out DIGITS    last complete frame's decimal points
//   frame_valid out 1         one-cycle pulse when bcd/dp update
//   frame_err   out 1         with frame_valid: some digit was undecodable
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned STABLE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            segment,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     dp,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int unsigned CntW = $clog2(STABLE + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    state_e                   state_q, state_d;
    logic [7:0]               seg_q, seg_d;
    logic [DIGITS-1:0]        sel_q, sel_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic [DIGITS-1:0]        mask_q, mask_d;
    logic [DIGITS-1:0][3:0]   slot_nib_q, slot_nib_d;
    logic [DIGITS-1:0]        slot_dp_q, slot_dp_d;
    logic [DIGITS-1:0]        slot_err_q, slot_err_d;
    logic [4*DIGITS-1:0]      bcd_q, bcd_d;
    logic [DIGITS-1:0]        dp_q, dp_d;
    logic                     fv_q, fv_d;
    logic                     fe_q, fe_d;

    logic       in_valid;
    logic       changed;
    logic       accept;
    logic [3:0] dec_nib;
    logic       dec_dp;
    logic       dec_err;

    // Decode always works on the registered sample that is being accepted.
    seg_capture_segdecode u_segdecode (
        .seg_i    (seg_q),
        .nibble_o (dec_nib),
        .dp_o     (dec_dp),
        .err_o    (dec_err)
    );

    assign in_valid = $onehot(digit_sel);
    assign changed  = (segment != seg_q) || (digit_sel != sel_q);
    assign seg_d    = segment;
    assign sel_d    = digit_sel;

    // Stability counter: 0 while the select is invalid, 1 on a new sample, saturates at STABLE.
    always_comb begin
        cnt_d = cnt_q;
        if (!in_valid) begin
            cnt_d = '0;
        end else if (changed) begin
            cnt_d = CntW'(1);
        end else if (cnt_q < CntW'(STABLE)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (in_valid) state_d = StSettle;
            end
            StSettle: begin
                if (!in_valid) begin
                    state_d = StIdle;
                end else if (accept && !changed) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (changed) state_d = in_valid ? StSettle : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM output: accept once the sample has been seen STABLE times in a row.
    always_comb begin
        accept = (state_q == StSettle) && (cnt_q == CntW'(STABLE));
    end

    // Slot, mask, timeout and frame publishing.
    always_comb begin
        tmo_d      = tmo_q;
        mask_d     = mask_q;
        slot_nib_d = slot_nib_q;
        slot_dp_d  = slot_dp_q;
        slot_err_d = slot_err_q;
        bcd_d      = bcd_q;
        dp_d       = dp_q;
        fv_d       = 1'b0;
        fe_d       = 1'b0;
        if (accept) begin
            tmo_d = '0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (sel_q[i]) begin
                    slot_nib_d[i] = dec_nib;
                    slot_dp_d[i]  = dec_dp;
                    slot_err_d[i] = dec_err;
                end
            end
            mask_d = mask_q | sel_q;
            if (&mask_d) begin
                bcd_d  = slot_nib_d;
                dp_d   = slot_dp_d;
                fe_d   = |slot_err_d;
                fv_d   = 1'b1;
                mask_d = '0;
            end
        end else begin
            if (tmo_q < TmoW'(TIMEOUT)) begin
                tmo_d = tmo_q + TmoW'(1);
            end else begin
                // Stale partial frame: drop it without touching the published outputs.
                mask_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            mask_q     <= '0;
            slot_nib_q <= '0;
            slot_dp_q  <= '0;
            slot_err_q <= '0;
            bcd_q      <= '0;
            dp_q       <= '0;
            fv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            mask_q     <= mask_d;
            slot_nib_q <= slot_nib_d;
            slot_dp_q  <= slot_dp_d;
            slot_err_q <= slot_err_d;
            bcd_q      <= bcd_d;
            dp_q       <= dp_d;
            fv_q       <= fv_d;
            fe_q       <= fe_d;
        end
    end

    assign bcd         = bcd_q;
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed bench for seg_capture (DIGITS=4, STABLE=4, TIMEOUT=1024).
// Inputs change 1 time unit after a rising edge; a pattern driven that way is first
// sampled at the next edge (k=1) and accepted at edge k=5.
module tb_seg_capture;

    localparam int unsigned Timeout = 1024;

    logic        clk;
    logic        rst_n;
    logic [7:0]  segment;
    logic [3:0]  digit_sel;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        frame_err;

    int tests_run;
    int fails;
    int pulses;
    int err_idle;

    seg_capture #(
        .DIGITS  (4),
        .STABLE  (4),
        .TIMEOUT (Timeout)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segment     (segment),
        .digit_sel   (digit_sel),
        .bcd         (bcd),
        .dp          (dp),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Background pulse counter and frame_err-without-valid watcher.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) pulses++;
        if (frame_valid !== 1'b1 && frame_err !== 1'b0) err_idle++;
    end

    // Drive one pattern for n cycles; report the first edge (1-based) with frame_valid, else 0.
    task automatic drive(input logic [3:0] sel, input logic [7:0] pat, input int n,
                         output int pulse_at);
        segment   = pat;
        digit_sel = sel;
        pulse_at  = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1 && pulse_at == 0) pulse_at = k;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        segment   = 8'h00;
        digit_sel = 4'b0000;
        #2;
        tests_run++;
        if (bcd !== 16'h0000) begin
            fails++;
            $display("FAIL reset_bcd: got %h expected 0000", bcd);
        end
        tests_run++;
        if (dp !== 4'b0000 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got dp=%b fv=%b fe=%b expected 0 0 0",
                     dp, frame_valid, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean_frame();
        int p0, p1, p2, p3;
        drive(4'b0001, 8'hFC, 8, p0);
        drive(4'b0010, 8'h60, 8, p1);
        drive(4'b0100, 8'hDA, 8, p2);
        segment   = 8'hF2;
        digit_sel = 4'b1000;
        p3 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1 && p3 == 0) begin
                p3 = k;
                tests_run++;
                if (bcd !== 16'h3210 || dp !== 4'b0000 || frame_err !== 1'b0) begin
                    fails++;
                    $display("FAIL clean_frame: got bcd=%h dp=%b fe=%b expected 3210 0000 0",
                             bcd, dp, frame_err);
                end
            end
        end
        tests_run++;
        if ({p0, p1, p2} !== {32'd0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL clean_early_pulse: got %0d %0d %0d expected 0 0 0", p0, p1, p2);
        end
        tests_run++;
        if (p3 !== 5) begin
            fails++;
            $display("FAIL clean_timing: got edge %0d expected 5", p3);
        end
        tests_run++;
        if (frame_valid !== 1'b0 || bcd !== 16'h3210) begin
            fails++;
            $display("FAIL clean_hold: got fv=%b bcd=%h expected 0 3210", frame_valid, bcd);
        end
    endtask

    task automatic test_glitch();
        int p, sum, start;
        start = pulses;
        sum = 0;
        drive(4'b0001, 8'hB6, 8, p); sum += p;
        drive(4'b0010, 8'h02, 3, p); sum += p;   // too short to accept
        drive(4'b0010, 8'hBE, 8, p); sum += p;
        drive(4'b0100, 8'hE0, 8, p); sum += p;
        drive(4'b1000, 8'h02, 2, p); sum += p;
        drive(4'b0000, 8'h02, 2, p); sum += p;   // select gap restarts the count
        drive(4'b1000, 8'h02, 2, p); sum += p;
        tests_run++;
        if (sum !== 0) begin
            fails++;
            $display("FAIL glitch_no_early_pulse: got pulse edge sum %0d expected 0", sum);
        end
        drive(4'b1000, 8'hFE, 8, p);
        tests_run++;
        if (p !== 5) begin
            fails++;
            $display("FAIL glitch_timing: got edge %0d expected 5", p);
        end
        tests_run++;
        if (bcd !== 16'h8765 || frame_err !== 1'b0 || pulses - start !== 1) begin
            fails++;
            $display("FAIL glitch_frame: got bcd=%h fe=%b pulses=%0d expected 8765 0 1",
                     bcd, frame_err, pulses - start);
        end
    endtask

    task automatic test_blank_err();
        int p;
        logic [15:0] bcd_s;
        logic [3:0]  dp_s;
        logic        fe_s;
        drive(4'b0001, 8'h80, 8, p);
        drive(4'b0010, 8'hFD, 8, p);
        drive(4'b0100, 8'h00, 8, p);
        segment   = 8'hF2;
        digit_sel = 4'b1000;
        p = 0;
        bcd_s = 16'h0;
        dp_s = 4'h0;
        fe_s = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1 && p == 0) begin
                p = k;
                bcd_s = bcd;
                dp_s = dp;
                fe_s = frame_err;
            end
        end
        tests_run++;
        if (p !== 5) begin
            fails++;
            $display("FAIL blank_timing: got edge %0d expected 5", p);
        end
        tests_run++;
        if (bcd_s !== 16'h3A0F) begin
            fails++;
            $display("FAIL blank_bcd: got %h expected 3A0F", bcd_s);
        end
        tests_run++;
        if (dp_s !== 4'b0010 || fe_s !== 1'b1) begin
            fails++;
            $display("FAIL blank_dp_err: got dp=%b fe=%b expected 0010 1", dp_s, fe_s);
        end
    endtask

    task automatic test_timeout();
        int p, start;
        drive(4'b0001, 8'h60, 8, p);
        drive(4'b0010, 8'hDA, 8, p);
        drive(4'b0100, 8'hF2, 8, p);
        start = pulses;
        drive(4'b0000, 8'h00, Timeout + 8, p);
        // Only digit 3 now: must not complete the discarded partial frame.
        drive(4'b1000, 8'hE0, 8, p);
        tests_run++;
        if (pulses - start !== 0 || bcd !== 16'h3A0F) begin
            fails++;
            $display("FAIL timeout_discard: got pulses=%0d bcd=%h expected 0 3A0F",
                     pulses - start, bcd);
        end
        drive(4'b0001, 8'h66, 8, p);
        drive(4'b0010, 8'hB6, 8, p);
        drive(4'b0100, 8'hBE, 8, p);
        tests_run++;
        if (p !== 5 || pulses - start !== 1 || bcd !== 16'h7654) begin
            fails++;
            $display("FAIL timeout_new_frame: got edge=%0d pulses=%0d bcd=%h expected 5 1 7654",
                     p, pulses - start, bcd);
        end
    endtask

    task automatic test_reset_mid();
        int p, pa, pb;
        drive(4'b0001, 8'hFE, 8, p);
        drive(4'b0010, 8'hF6, 8, p);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bcd !== 16'h0000 || dp !== 4'b0000 || frame_valid !== 1'b0 || frame_err !== 1'b0)
        begin
            fails++;
            $display("FAIL reset_mid_outputs: got bcd=%h dp=%b fv=%b fe=%b expected all 0",
                     bcd, dp, frame_valid, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(4'b0100, 8'hDA, 8, pa);
        drive(4'b1000, 8'hF2, 8, pb);
        tests_run++;
        if (pa !== 0 || pb !== 0) begin
            fails++;
            $display("FAIL reset_mid_mask: got edges %0d %0d expected 0 0", pa, pb);
        end
        drive(4'b0001, 8'hFC, 8, pa);
        drive(4'b0010, 8'h60, 8, pb);
        tests_run++;
        if (pa !== 0 || pb !== 5 || bcd !== 16'h3210) begin
            fails++;
            $display("FAIL reset_mid_refill: got edges %0d %0d bcd=%h expected 0 5 3210",
                     pa, pb, bcd);
        end
    endtask

    task automatic test_static();
        int p, start;
        start = pulses;
        drive(4'b0001, 8'hFC, 5000, p);
        tests_run++;
        if (pulses - start !== 0 || bcd !== 16'h3210) begin
            fails++;
            $display("FAIL static_no_frame: got pulses=%0d bcd=%h expected 0 3210",
                     pulses - start, bcd);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        pulses    = 0;
        err_idle  = 0;
        test_reset();
        test_clean_frame();
        test_glitch();
        test_blank_err();
        test_timeout();
        test_reset_mid();
        test_static();
        tests_run++;
        if (err_idle !== 0) begin
            fails++;
            $display("FAIL err_without_valid: got %0d cycles expected 0", err_idle);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
